mips_multicycle_control: RTL and testbench

//  Multi-cycle MIPS main control FSM; next generation of the single-cycle opcode decoder.

---
 rtl/mips_ctrl_pkg.sv | 36 +++
 rtl/mips_ctrl_outdec.sv | 86 ++++++++
 rtl/mips_multicycle_control.sv | 116 +++++++++++
 tb/tb_mips_multicycle_control.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes and mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> datapath control-line decode (Moore, except IRWrite/PCWrite in FETCH).
// The JUMP decode exists only when MIPS_CTRL_JUMP_EN is defined.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        // PC+4 and IR load only commit once the fetch read completes
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH2;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory-ready wait counter and timeout abort.
// Define MIPS_CTRL_JUMP_EN to decode opcode 2 (j) into the JUMP state; otherwise it is illegal.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            illegal_op,
  output logic            mem_err,
  output logic [3:0]      state
);

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wait_cnt;
  logic [OP_W-1:0]        op_q;
  logic                   is_wait;
  logic                   timeout;
  logic                   dec_illegal;

  assign state   = state_q;
  assign is_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // mem_ready in the expiry cycle wins, so the timeout needs it low
  assign timeout = is_wait && !mem_ready && (MEM_TIMEOUT != 0) &&
                   (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    dec_illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        if (opcode == OP_W'(OP_RTYPE)) state_d = S_EXEC;
        else if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW)) state_d = S_MEMADR;
        else if (opcode == OP_W'(OP_BEQ)) state_d = S_BRANCH;
`ifdef MIPS_CTRL_JUMP_EN
        else if (opcode == OP_W'(OP_J)) state_d = S_JUMP;
`endif
        else begin
          state_d     = S_FETCH;
          dec_illegal = 1'b1;
        end
      end
      S_MEMADR: state_d = (op_q == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_EXEC:  state_d = S_RWB;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_op <= dec_illegal;
      mem_err    <= timeout;
      // Any state entry (including FETCH re-entry after a fetch timeout) restarts the count
      if (state_d != state_q || timeout) wait_cnt <= '0;
      else if (wait_cnt != '1) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) op_q <= opcode;
  end

  mips_ctrl_outdec u_outdec (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: a driver walks instructions phase by phase, queueing expected per-cycle state/controls.
module tb_mips_multicycle_control;

  localparam int MT = 15;
`ifdef MIPS_CTRL_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, mem_err;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  mips_multicycle_control #(.OP_W(6), .TIMEOUT_W(4), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctl;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  bit   pend_ill = 1'b0;
  bit   pend_err = 1'b0;
  int   cyc = 0;

  wire [17:0] act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_err};

  // Control lines each phase is documented to assert; everything else is 0
  function automatic logic [15:0] ctl_of(int st, bit rdy);
    logic pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ao, ps;
    {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0: begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iord = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; end
      9: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(int st, bit rdy);
    exp_t e;
    e.st  = 4'(st);
    e.ctl = {ctl_of(st, rdy), pend_ill, pend_err};
    e.cyc = cyc;
    pend_ill = 1'b0;
    pend_err = 1'b0;
    cyc++;
    q.push_back(e);
  endtask

  task automatic step(int st, bit rdy, logic [5:0] op);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = rdy;
    opcode = op;
    push(st, rdy);
  endtask

  task automatic reset_step();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = rop();
    pend_ill = 1'b0;
    pend_err = 1'b0;
    push(0, 1'b0);
  endtask

  // One instruction: fw fetch waits, mw memory waits (mw > MT means memory never answers)
  task automatic run_instr(logic [5:0] op, int fw, int mw);
    int s, n;
    for (int i = 0; i < fw; i++) step(0, 1'b0, rop());
    step(0, 1'b1, rop());
    step(1, rb(), op);
    if (op == 6'd0) begin
      step(6, rb(), rop());
      step(7, rb(), rop());
    end else if (op == 6'd35 || op == 6'd43) begin
      step(2, rb(), rop());
      s = (op == 6'd35) ? 3 : 5;
      n = (mw > MT) ? MT + 1 : mw;
      for (int i = 0; i < n; i++) step(s, 1'b0, rop());
      if (mw > MT) pend_err = 1'b1;
      else begin
        step(s, 1'b1, rop());
        if (op == 6'd35) step(4, rb(), rop());
      end
    end else if (op == 6'd4) begin
      step(8, rb(), rop());
    end else if (op == 6'd2 && JEN) begin
      step(9, rb(), rop());
    end else begin
      pend_ill = 1'b1;
    end
  endtask

  initial begin : driver
    logic [5:0] op;
    int mw, sel;
    reset_step();
    reset_step();
    run_instr(6'd0, 0, 0);
    run_instr(6'd35, 0, 3);
    run_instr(6'd43, 0, 99);
    run_instr(6'd43, 1, 15);
    run_instr(6'd35, 1, 16);
    run_instr(6'd4, 0, 0);
    run_instr(6'd2, 0, 0);
    run_instr(6'd63, 0, 0);
    // Abandon a load mid-MEMRD with an asynchronous reset
    step(0, 1'b1, rop());
    step(1, 1'b0, 6'd35);
    step(2, 1'b0, rop());
    step(3, 1'b0, rop());
    step(3, 1'b0, rop());
    reset_step();
    run_instr(6'd0, 2, 0);
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd2;
        5: op = 6'd63;
        default: op = rop();
      endcase
      mw = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      run_instr(op, $urandom_range(0, 3), mw);
    end
    run_instr(6'd0, 0, 0);
    done = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (state !== e.st) begin
          failures++;
          $display("FAIL cyc%0d state: got %0d expected %0d", e.cyc, state, e.st);
        end
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL cyc%0d controls(state %0d): got %b expected %b", e.cyc, e.st, act, e.ctl);
        end
      end else if (done) begin
        break;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d expectations pending", q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
